// File: rtl/pipeline_pkg.sv
// Shared pipeline types.
//   hazard_state_e      : hazard controller FSM states (RUN, FLUSH, MEM_WAIT)
//   hazard_ctrl_signals : the six stall/flush enables driven by hazard_ctrl
package pipeline;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
    } hazard_ctrl_signals;

endpackage

// File: rtl/perf_counter.sv
// 32-bit wrapping event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count this cycle
//   count      : current count, wraps at 2^32
module perf_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives stall/flush enables for PC, IF/ID,
// ID/EX and EX/MEM from the decode/execute/memory stage status.
//   id_valid, id_rs1_addr, id_rs2_addr   : ID stage instruction and sources
//   ex_valid, ex_rd_addr, ex_mm_re       : EX stage instruction, dest, is-load
//   ex_redirect                          : EX resolved jump / taken branch
//   mem_req, mem_ack                     : MEM stage access and its completion
//   pc_stall, *_stall, *_flush           : pipeline register enables (Mealy)
//   mem_timeout                          : sticky, memory wait too long
//   perf_stall_cnt, perf_flush_cnt       : cycles with any stall / any flush
// Priority each cycle: memory wait > redirect > load-use.
module hazard_ctrl
    import pipeline::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mm_re,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_timeout,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);
    localparam logic       TIMEOUT_EN = (MEM_TIMEOUT != 0);

    hazard_state_e      hz_state_reg, hz_state_next;
    logic [2:0]         flush_cnt_reg, flush_cnt_next;
    logic [7:0]         wait_cnt_reg, wait_cnt_next;
    logic               mem_timeout_reg, mem_timeout_next;
    hazard_ctrl_signals ctl;
    logic               mem_wait;
    logic               load_use;

    assign mem_wait = mem_req && !mem_ack;
    assign load_use = id_valid && ex_valid && ex_mm_re && (ex_rd_addr != '0) &&
                      ((id_rs1_addr == ex_rd_addr) || (id_rs2_addr == ex_rd_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz_state_reg    <= RUN;
            flush_cnt_reg   <= '0;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            hz_state_reg    <= hz_state_next;
            flush_cnt_reg   <= flush_cnt_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    always_comb begin
        ctl              = '0;
        hz_state_next    = hz_state_reg;
        flush_cnt_next   = flush_cnt_reg;
        wait_cnt_next    = '0;
        mem_timeout_next = mem_timeout_reg;

        if (mem_wait) begin
            // Freeze the whole pipe; a pending squash count survives the wait.
            ctl.pc_stall     = 1'b1;
            ctl.if_id_stall  = 1'b1;
            ctl.id_ex_stall  = 1'b1;
            ctl.ex_mem_stall = 1'b1;
            hz_state_next    = MEM_WAIT;
            // The entry cycle counts as a wait cycle; saturate so it never wraps.
            wait_cnt_next    = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;
            if (TIMEOUT_EN && (hz_state_reg == MEM_WAIT) && (wait_cnt_reg >= TIMEOUT_M1)) begin
                mem_timeout_next = 1'b1;
            end
        end else if (ex_redirect) begin
            // Squash both younger stages; load-use is irrelevant on a wrong path.
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
            flush_cnt_next  = FLUSH_LOAD;
            hz_state_next   = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
        end else begin
            case (hz_state_reg)
                MEM_WAIT: begin
                    hz_state_next = (flush_cnt_reg != 3'd0) ? FLUSH : RUN;
                end
                FLUSH: begin
                    ctl.if_id_flush = 1'b1;
                    if (flush_cnt_reg != 3'd0) begin
                        flush_cnt_next = flush_cnt_reg - 3'd1;
                    end
                    hz_state_next = (flush_cnt_reg <= 3'd1) ? RUN : FLUSH;
                end
                default: begin
                    hz_state_next = RUN;
                end
            endcase
            // Hold the consumer in ID and insert a bubble so the load reaches MEM.
            if ((hz_state_reg != MEM_WAIT) && load_use) begin
                ctl.pc_stall    = 1'b1;
                ctl.if_id_stall = 1'b1;
                ctl.id_ex_flush = 1'b1;
            end
        end
    end

    assign pc_stall     = ctl.pc_stall;
    assign if_id_stall  = ctl.if_id_stall;
    assign id_ex_stall  = ctl.id_ex_stall;
    assign ex_mem_stall = ctl.ex_mem_stall;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign mem_timeout  = mem_timeout_reg;

    // Index 0 counts stall cycles, index 1 counts flush cycles.
    logic [1:0]  perf_en;
    logic [31:0] perf_cnt [2];

    assign perf_en[0] = ctl.pc_stall | ctl.if_id_stall | ctl.id_ex_stall | ctl.ex_mem_stall;
    assign perf_en[1] = ctl.if_id_flush | ctl.id_ex_flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            perf_counter u_perf_counter (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (perf_en[gi]),
                .count (perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_stall_cnt = perf_cnt[0];
    assign perf_flush_cnt = perf_cnt[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: a cycle-level behavioural model checks
// every output on every clock, plus literal expectations for key cycles.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int FC = 1;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1_addr = '0;
    logic [AW-1:0] id_rs2_addr = '0;
    logic          ex_valid = 1'b0;
    logic [AW-1:0] ex_rd_addr = '0;
    logic          ex_mm_re = 1'b0;
    logic          ex_redirect = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ack = 1'b0;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic          if_id_flush, id_ex_flush, mem_timeout;
    logic [31:0]   perf_stall_cnt, perf_flush_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W   (AW),
        .FLUSH_CYCLES (FC),
        .MEM_TIMEOUT  (MT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .ex_valid       (ex_valid),
        .ex_rd_addr     (ex_rd_addr),
        .ex_mm_re       (ex_mm_re),
        .ex_redirect    (ex_redirect),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .id_ex_stall    (id_ex_stall),
        .ex_mem_stall   (ex_mem_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .mem_timeout    (mem_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owed_flush : if_id squash cycles still owed after a redirect
    // in_wait    : previous cycle was a memory wait
    // wait_run   : length of the current run of consecutive wait cycles
    int          owed_flush;
    bit          in_wait;
    int          wait_run;
    bit          m_timeout;
    int unsigned m_stalls, m_flushes;
    bit          e_pc, e_ifs, e_ies, e_ems, e_iff, e_ief, w, lu, was_wait;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owed_flush = 0;
            in_wait    = 1'b0;
            wait_run   = 0;
            m_timeout  = 1'b0;
            m_stalls   = 0;
            m_flushes  = 0;
        end else begin
            w  = mem_req && !mem_ack;
            lu = id_valid && ex_valid && ex_mm_re && (ex_rd_addr != 0) &&
                 (id_rs1_addr == ex_rd_addr || id_rs2_addr == ex_rd_addr);
            {e_pc, e_ifs, e_ies, e_ems, e_iff, e_ief} = 6'b0;
            if (w) begin
                {e_pc, e_ifs, e_ies, e_ems} = 4'b1111;
            end else if (ex_redirect) begin
                {e_iff, e_ief} = 2'b11;
            end else if (!in_wait) begin
                if (owed_flush > 0) e_iff = 1'b1;
                if (lu) begin
                    e_pc = 1'b1; e_ifs = 1'b1; e_ief = 1'b1;
                end
            end
            chk("model pc_stall",     pc_stall,     e_pc);
            chk("model if_id_stall",  if_id_stall,  e_ifs);
            chk("model id_ex_stall",  id_ex_stall,  e_ies);
            chk("model ex_mem_stall", ex_mem_stall, e_ems);
            chk("model if_id_flush",  if_id_flush,  e_iff);
            chk("model id_ex_flush",  id_ex_flush,  e_ief);
            chk("model mem_timeout",  mem_timeout,  m_timeout);
            chk("model perf_stall",   perf_stall_cnt, m_stalls);
            chk("model perf_flush",   perf_flush_cnt, m_flushes);
            // advance to the state seen after the coming edge
            if (e_pc | e_ifs | e_ies | e_ems) m_stalls++;
            if (e_iff | e_ief) m_flushes++;
            was_wait = in_wait;
            if (w) begin
                wait_run++;
                // timeout once a run of waits reaches MT (needs a prior wait cycle)
                if (was_wait && MT != 0 && wait_run >= MT) m_timeout = 1'b1;
                in_wait = 1'b1;
            end else begin
                wait_run = 0;
                in_wait  = 1'b0;
                if (ex_redirect) owed_flush = FC;
                else if (!was_wait && owed_flush > 0) owed_flush--;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; ex_valid = 0; ex_mm_re = 0; ex_redirect = 0;
        mem_req = 0; mem_ack = 0;
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    endtask

    task automatic set_load_use(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                                input logic [AW-1:0] rs2);
        id_valid = 1; ex_valid = 1; ex_mm_re = 1;
        ex_rd_addr = rd; id_rs1_addr = rs1; id_rs2_addr = rs2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("reset outputs", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                              if_id_flush, id_ex_flush, mem_timeout}, 32'd0);
        chk("reset perf_stall", perf_stall_cnt, 32'd0);
        chk("reset perf_flush", perf_flush_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1;
    endtask

    initial begin
        idle();
        #3;
        chk("por outputs", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                            if_id_flush, id_ex_flush, mem_timeout}, 32'd0);
        do_reset();
        $display("phase: reset done");

        // load-use: rd=5, rs2=5
        next_cycle(); set_load_use(5'd5, 5'd3, 5'd5);
        settle();
        chk("lu pc_stall", pc_stall, 1); chk("lu if_id_stall", if_id_stall, 1);
        chk("lu id_ex_flush", id_ex_flush, 1); chk("lu id_ex_stall", id_ex_stall, 0);
        next_cycle(); ex_mm_re = 0; ex_rd_addr = 5'd7;   // load moved on, bubble in EX
        settle();
        chk("lu after pc_stall", pc_stall, 0); chk("lu after id_ex_flush", id_ex_flush, 0);
        next_cycle(); set_load_use(5'd0, 5'd0, 5'd0);
        settle();
        chk("lu rd0 pc_stall", pc_stall, 0);
        $display("phase: load-use done");

        // redirect pulse, FLUSH_CYCLES=1
        next_cycle(); idle(); ex_redirect = 1;
        settle();
        chk("rd c0 if_id_flush", if_id_flush, 1); chk("rd c0 id_ex_flush", id_ex_flush, 1);
        next_cycle(); ex_redirect = 0;
        settle();
        chk("rd c1 if_id_flush", if_id_flush, 1); chk("rd c1 id_ex_flush", id_ex_flush, 0);
        next_cycle();
        settle();
        chk("rd c2 if_id_flush", if_id_flush, 0);
        $display("phase: redirect done");

        // redirect coinciding with load-use, then load-use during FLUSH
        next_cycle(); set_load_use(5'd9, 5'd9, 5'd1); ex_redirect = 1;
        settle();
        chk("rd+lu pc_stall", pc_stall, 0); chk("rd+lu if_id_flush", if_id_flush, 1);
        next_cycle(); ex_redirect = 0;
        settle();
        chk("flush+lu pc_stall", pc_stall, 1);
        next_cycle(); idle();
        settle();

        // memory wait: 3 wait cycles then ack
        next_cycle(); do_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle(); mem_req = 1; mem_ack = 0;
            settle();
            chk("mw stalls", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall}, 32'hF);
            chk("mw flushes", {if_id_flush, id_ex_flush}, 32'd0);
        end
        next_cycle(); mem_ack = 1;
        settle();
        chk("mw ack stalls", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall}, 32'd0);
        next_cycle(); idle();
        settle();
        chk("mw perf_stall", perf_stall_cnt, 32'd3);
        $display("phase: memory wait done");

        // redirect held during a memory wait, with load-use present
        for (int i = 0; i < 2; i++) begin
            next_cycle(); set_load_use(5'd4, 5'd4, 5'd4); mem_req = 1; ex_redirect = 1;
            settle();
            chk("rw wait if_id_flush", if_id_flush, 0);
        end
        next_cycle(); mem_ack = 1;
        settle();
        chk("rw ack if_id_flush", if_id_flush, 1); chk("rw ack id_ex_flush", id_ex_flush, 1);
        chk("rw ack pc_stall", pc_stall, 0); chk("rw ack if_id_stall", if_id_stall, 0);
        next_cycle(); idle();
        settle();
        chk("rw c1 if_id_flush", if_id_flush, 1); chk("rw c1 id_ex_flush", id_ex_flush, 0);
        next_cycle();
        settle();
        chk("rw c2 if_id_flush", if_id_flush, 0);
        $display("phase: redirect during wait done");

        // timeout with MEM_TIMEOUT=4: six wait cycles, then ack
        next_cycle(); do_reset();
        for (int i = 1; i <= 6; i++) begin
            next_cycle(); mem_req = 1; mem_ack = 0;
            settle();
            chk("to mem_timeout", mem_timeout, (i >= 5) ? 1 : 0);
        end
        next_cycle(); mem_ack = 1;
        settle();
        chk("to ack stall", pc_stall, 0); chk("to ack mem_timeout", mem_timeout, 1);
        next_cycle(); idle();
        settle();
        chk("to sticky", mem_timeout, 1);
        $display("phase: timeout done");

        // reset asserted mid-FLUSH
        next_cycle(); ex_redirect = 1;
        settle();
        next_cycle(); ex_redirect = 0;
        #2;
        chk("mf before if_id_flush", if_id_flush, 1);
        rst_n = 0;
        #1;
        chk("mf async if_id_flush", if_id_flush, 0);
        chk("mf async timeout", mem_timeout, 0);
        chk("mf async perf_flush", perf_flush_cnt, 0);
        @(negedge clk);
        #2;
        rst_n = 1;
        next_cycle();
        settle();
        chk("mf post if_id_flush", if_id_flush, 0);
        $display("phase: mid-flush reset done");

        next_cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the in-order core: watches the decode, execute and memory stages and drives stall/flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It resolves load-use hazards, squashes wrong-path instructions after a taken jump/branch, and freezes the pipe while a data-memory access waits for acknowledge. It sits beside `idu`, consuming the decoded register addresses and memory-access flags, and feeds the pipeline register enables in the core top.

## Interface
- `REG_ADDR_W`, 5: register address width.
- `FLUSH_CYCLES`, 1: extra squash cycles after a redirect, covering fetch latency; range 0-7.
- `MEM_TIMEOUT`, 255: MEM_WAIT cycles before `mem_timeout` sets; 0 disables.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs1_addr`, `id_rs2_addr` in REG_ADDR_W: source registers from `idu`.
- `ex_valid` in 1: EX stage holds a real instruction.
- `ex_rd_addr` in REG_ADDR_W: EX destination register.
- `ex_mm_re` in 1: EX instruction is a load.
- `ex_redirect` in 1: EX resolved a jump or taken branch.
- `mem_req` in 1: MEM stage issuing a load/store (`mm_re | mm_we`).
- `mem_ack` in 1: data memory completes the access this cycle.
- `pc_stall` out 1: hold PC.
- `if_id_stall`, `id_ex_stall`, `ex_mem_stall` out 1: hold the named register.
- `if_id_flush`, `id_ex_flush` out 1: load a bubble into the named register.
- `mem_timeout` out 1: sticky; memory wait exceeded `MEM_TIMEOUT`.
- `perf_stall_cnt`, `perf_flush_cnt` out 32: cycles with any stall / any flush; wrap at 2^32.

## Operation
- State register `hz_state`: RUN, FLUSH, MEM_WAIT. Plus `flush_cnt` (3 bits) and `wait_cnt` (8 bits).
- Outputs are Mealy: a function of the registered state and the current-cycle inputs.
- Priority within one cycle: memory wait > redirect > load-use.
- Memory wait applies in any state when `mem_req && !mem_ack`:
  - assert `pc_stall` and all three `*_stall` outputs; no flushes;
  - next state is MEM_WAIT; `flush_cnt` holds.
- MEM_WAIT:
  - while `mem_req && !mem_ack`: stay, with `wait_cnt` incrementing.
  - when `mem_ack` is set: stalls drop that same cycle. Next state is FLUSH if `flush_cnt != 0`, otherwise RUN. `wait_cnt` clears.
  - a redirect held in EX during the wait is acted on in the ack cycle.
- Redirect, when `ex_redirect` is set and there is no memory wait:
  - assert `if_id_flush` and `id_ex_flush`.
  - if `FLUSH_CYCLES > 0`: load `flush_cnt = FLUSH_CYCLES` and go to FLUSH.
  - any load-use stall is suppressed that cycle.
- FLUSH:
  - assert `if_id_flush` each cycle and decrement `flush_cnt`;
  - go to RUN when the count reaches 0;
  - a new `ex_redirect` reloads the count.
- Load-use, in RUN or FLUSH with no higher-priority event:
  - condition: `id_valid && ex_valid && ex_mm_re && ex_rd_addr != 0 && (id_rs1_addr == ex_rd_addr || id_rs2_addr == ex_rd_addr)`.
  - response: assert `pc_stall`, `if_id_stall` and `id_ex_flush` for exactly one cycle (the bubble moves the load to MEM, so the condition clears).
- Timeout: `mem_timeout` sets when `wait_cnt == MEM_TIMEOUT-1` in MEM_WAIT with no ack. It stays set until reset; the stalls continue regardless.
- Perf counters increment on cycles where any stall output or any flush output is high, respectively.

## Timing
- Reset (async assert, sync-safe release) gives: `hz_state` = RUN, `flush_cnt` = 0, `wait_cnt` = 0, `mem_timeout` = 0, perf counters = 0.
- Outputs with idle inputs are all 0 during and after reset.
- Zero-cycle latency from hazard inputs to stall/flush outputs (combinational path).
- State updates take effect in the following cycle.
- Redirect with `FLUSH_CYCLES = N`: flushes are asserted for 1+N consecutive cycles, provided there is no memory wait.
- Redirect arriving during MEM_WAIT: the flush starts in the ack cycle.
- Load-use coinciding with a redirect: only the flush is asserted.
- A mid-operation reset aborts FLUSH and MEM_WAIT immediately.

## Structure
- Add to package `pipeline`: `hazard_state_e` enum (RUN, FLUSH, MEM_WAIT) and `hazard_ctrl_signals` struct bundling the six stall/flush outputs.
- One sub-module, `perf_counter`: a 32-bit wrapping counter with `en`, instantiated twice.

## Test plan
- Load-use: EX holds a load with rd=5, ID has rs2=5, both valid. Expect `pc_stall`=`if_id_stall`=`id_ex_flush`=1 for one cycle, then 0. With rd=0, expect no stall.
- Redirect, `FLUSH_CYCLES`=1: pulse `ex_redirect`. Expect `if_id_flush`=1 for 2 cycles and `id_ex_flush`=1 for the first cycle only; the state returns to RUN.
- Memory wait: `mem_req`=1 with `mem_ack` low for 3 cycles, then high. Expect all stalls =1 for 3 cycles, 0 in the ack cycle, and `perf_stall_cnt`=3.
- Redirect held during a memory wait: the flush starts exactly in the ack cycle and the load-use condition is ignored.
- Timeout with `MEM_TIMEOUT`=4: hold `mem_req` with no ack for 6 cycles. `mem_timeout` rises after the 4th wait cycle and stays high after the ack.
- Assert `rst_n`=0 mid-FLUSH: all outputs drop asynchronously and the state is RUN on release.
